// File: rtl/neuron_scheduler.sv
// neuron_scheduler: runs one bitstream neuron window and counts its output ones; optional NEURON_SCHED_FIRE_EN adds result_fire.
module neuron_scheduler #(
  parameter int INPUT_SIZE = 2,
  parameter int WEIGHT_LEN = 16,
  parameter int WINDOW_LEN = 256,
  parameter int LATENCY = 2,
`ifdef NEURON_SCHED_FIRE_EN
  parameter int THRESHOLD = WINDOW_LEN / 2,
`endif
  localparam int IW = INPUT_SIZE > 1 ? $clog2(INPUT_SIZE) : 1,
  localparam int OW = $clog2(WINDOW_LEN + 1),
  localparam int CW = $clog2(WINDOW_LEN + LATENCY)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cfg_valid,
  output logic                                 cfg_ready,
  input  logic [IW-1:0]                        cfg_index,
  input  logic [WEIGHT_LEN-1:0]                cfg_weight,
  input  logic                                 start,
  output logic                                 busy,
  output logic                                 neuron_n_rst,
  output logic                                 input_enable,
  output logic [INPUT_SIZE-1:0][WEIGHT_LEN-1:0] weight_values,
  input  logic                                 neuron_output,
  output logic                                 result_valid,
  input  logic                                 result_ready,
  output logic [OW-1:0]                        result_count
`ifdef NEURON_SCHED_FIRE_EN
  ,
  output logic                                 result_fire
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] ones_q, ones_d, count_q;
  logic [LATENCY-1:0] en_q;
  logic [INPUT_SIZE-1:0][WEIGHT_LEN-1:0] w_q;
  logic run_last, drain_last;
  assign run_last = state_q == RUN && cnt_q == CW'(WINDOW_LEN - 1);
  assign drain_last = state_q == DRAIN && cnt_q == CW'(WINDOW_LEN + LATENCY - 1);
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start ? RUN : IDLE;
      RUN:     state_d = run_last ? DRAIN : RUN;
      DRAIN:   state_d = drain_last ? DONE : DRAIN;
      default: state_d = result_ready ? IDLE : DONE;
    endcase
  end
  always_comb begin
    cfg_ready = state_q == IDLE;
    busy = state_q != IDLE;
    input_enable = state_q == RUN;
    neuron_n_rst = state_q == RUN || state_q == DRAIN;
    result_valid = state_q == DONE;
  end
  // one counter spans RUN then DRAIN, so DRAIN ends at WINDOW_LEN+LATENCY-1
  always_comb begin
    cnt_d = (state_q == RUN || state_q == DRAIN) ? cnt_q + 1'b1 : '0;
    ones_d = (state_q == IDLE) ? '0 : ones_q + OW'(en_q[LATENCY-1] & neuron_output);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ones_q <= '0;
      en_q <= '0;
      w_q <= '0;
      count_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ones_q <= ones_d;
      en_q <= LATENCY'({en_q, input_enable});
      if (drain_last) count_q <= ones_d;
      if (cfg_ready && cfg_valid)
        for (int i = 0; i < INPUT_SIZE; i++)
          if (32'(cfg_index) == i) w_q[i] <= cfg_weight;
    end
  end
`ifdef NEURON_SCHED_FIRE_EN
  logic fire_q;
  always_ff @(posedge clk) begin
    if (rst) fire_q <= 1'b0;
    else if (drain_last) fire_q <= ones_d >= OW'(THRESHOLD);
  end
  assign result_fire = fire_q;
`endif
  assign weight_values = w_q;
  assign result_count = count_q;
endmodule

// File: tb/tb_neuron_scheduler.sv
// tb_neuron_scheduler: randomized and directed checks of neuron_scheduler against a cycle-indexed evaluation model.
module tb_neuron_scheduler;
  localparam int W = 16;
  localparam int L = 2;
  logic clk = 0, rst = 1, cfg_valid = 0, start = 0, neuron_output = 0, result_ready = 0;
  logic [0:0] cfg_index = '0;
  logic [15:0] cfg_weight = '0;
  logic cfg_ready, busy, neuron_n_rst, input_enable, result_valid;
  logic [1:0][15:0] weight_values;
  logic [4:0] result_count;
`ifdef NEURON_SCHED_FIRE_EN
  logic result_fire;
`endif
  neuron_scheduler #(
    .INPUT_SIZE(2), .WEIGHT_LEN(16), .WINDOW_LEN(W), .LATENCY(L)
`ifdef NEURON_SCHED_FIRE_EN
    , .THRESHOLD(8)
`endif
  ) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_index(cfg_index), .cfg_weight(cfg_weight), .start(start), .busy(busy),
    .neuron_n_rst(neuron_n_rst), .input_enable(input_enable),
    .weight_values(weight_values), .neuron_output(neuron_output),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_count(result_count)
`ifdef NEURON_SCHED_FIRE_EN
    , .result_fire(result_fire)
`endif
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: m_k is the cycle number within an evaluation, cycle 1 being the first RUN cycle
  bit m_eval = 0, chk_en = 0;
  int m_k = 0, m_acc = 0, m_res = 0, pat = 0;
  logic [15:0] m_w [2];
  always @(posedge clk) begin
    if (rst) begin
      m_eval = 0; m_k = 0; m_acc = 0; m_res = 0; m_w[0] = 0; m_w[1] = 0;
    end else if (!m_eval) begin
      if (cfg_valid) m_w[cfg_index] = cfg_weight;
      if (start) begin m_eval = 1; m_k = 1; m_acc = 0; end
    end else begin
      if (m_k >= 1 + L && m_k <= W + L && neuron_output) m_acc++;
      if (m_k == W + L) m_res = m_acc;
      if (m_k > W + L && result_ready) m_eval = 0;
      else m_k++;
    end
  end
  always @(negedge clk) if (chk_en) begin
    check("cfg_ready", cfg_ready, !m_eval);
    check("busy", busy, m_eval);
    check("input_enable", input_enable, m_eval && m_k <= W);
    check("neuron_n_rst", neuron_n_rst, m_eval && m_k <= W + L);
    check("result_valid", result_valid, m_eval && m_k > W + L);
    check("result_count", result_count, m_res);
    check("weights", weight_values, {m_w[1], m_w[0]});
`ifdef NEURON_SCHED_FIRE_EN
    check("result_fire", result_fire, m_res >= 8);
`endif
  end
  always @(negedge clk) begin
    #2;
    neuron_output = pat == 1 ? 1'b1 :
                    pat == 2 ? (m_k == 1 || m_k == 2 || m_k == 19 || (m_k >= 3 && m_k <= 18 && m_k % 2 == 1)) :
                    pat == 3 ? (m_k >= 3 && m_k <= 9) : 1'($urandom_range(0, 1));
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask
  task automatic eval(input int p, input int exp_cnt, input int hold);
    int c;
    pat = p;
    start = 1;
    cyc();
    start = 0;
    cfg_valid = 1;
    cfg_index = 1'($urandom);
    cfg_weight = 16'($urandom);
    for (c = 1; c < 40 && !result_valid; c++) cyc();
    cfg_valid = 0;
    check("valid_cycle", c, 19);
    check("count_lit", result_count, exp_cnt);
    repeat (hold) begin
      start = 1;
      cyc();
      check("hold_valid", result_valid, 1);
      check("hold_busy", busy, 1);
      check("hold_count", result_count, exp_cnt);
    end
    start = 0;
    result_ready = 1;
    cyc();
    result_ready = 0;
    check("idle_after_ack", cfg_ready, 1);
  endtask
  initial begin
    @(posedge clk);
    #1;
    chk_en = 1;
    cyc();
    rst = 0;
    cfg_valid = 1; cfg_index = 0; cfg_weight = 16'h1234;
    cyc();
    cfg_index = 1; cfg_weight = 16'hABCD;
    cyc();
    cfg_valid = 0;
    check("wr_lit", weight_values, 32'hABCD1234);
    eval(1, 16, 0);
    check("busy_wr_lit", weight_values, 32'hABCD1234);
`ifdef NEURON_SCHED_FIRE_EN
    check("fire16_lit", result_fire, 1);
`endif
    eval(2, 8, 5);
`ifdef NEURON_SCHED_FIRE_EN
    check("fire8_lit", result_fire, 1);
`endif
    eval(3, 7, 0);
`ifdef NEURON_SCHED_FIRE_EN
    check("fire7_lit", result_fire, 0);
`endif
    pat = 1;
    start = 1;
    cyc();
    start = 0;
    repeat (7) cyc();
    rst = 1;
    cyc();
    rst = 0;
    check("abort_idle", cfg_ready, 1);
    check("abort_weights", weight_values, 0);
    check("abort_valid", result_valid, 0);
    eval(1, 16, 0);
    pat = 0;
    for (int i = 0; i < 1500; i++) begin
      cfg_valid = 1'($urandom_range(0, 1));
      cfg_index = 1'($urandom);
      cfg_weight = 16'($urandom);
      start = $urandom_range(0, 7) == 0;
      result_ready = $urandom_range(0, 2) == 0;
      rst = $urandom_range(0, 299) == 0;
      cyc();
    end
    rst = 0; cfg_valid = 0; start = 0; result_ready = 0;
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
